// File: rtl/prog_loader.sv
// prog_loader: byte-stream loader for the processor's instruction memory.
// Frame: length byte L (0 means 256 words), then per word the high byte
// and the low byte, then an XOR checksum over all data bytes. The processor
// is held in reset (cpu_rst=1) in every state except DONE.
//
// Optional build macro PROG_LOADER_OPCHECK_EN: each assembled word is
// checked against the processor ISA; an illegal word is not written and
// the load aborts to ERR.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start              begins a load (honoured in IDLE, DONE, ERR)
//   in_data/in_valid   stream byte and its valid
//   in_ready           loader accepts a byte (LEN, HI, LO, CSUM)
//   mem_we/addr/wdata  instruction memory write port, one strobe per word
//   cpu_rst            active-high processor reset
//   done / err         load finished with good checksum / load aborted
//   words_loaded       words written in the current or last load
module prog_loader #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [8:0] DEPTH = 9'(1 << ADDR_W);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEN  = 3'd1;
    localparam logic [2:0] S_HI   = 3'd2;
    localparam logic [2:0] S_LO   = 3'd3;
    localparam logic [2:0] S_CSUM = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;
    localparam logic [2:0] S_ERR  = 3'd6;

    logic [2:0]        state;
    logic [2:0]        next_state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] last_idx;
    logic [7:0]        hi_byte;
    logic [7:0]        csum;

    logic              acc_c;
    logic [8:0]        len_n_c;
    logic [15:0]       word_c;

    // in_ready is a registered decode of the state, so it never depends on in_valid
    assign acc_c   = in_valid && in_ready;
    assign len_n_c = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
    assign word_c  = {hi_byte, in_data};

`ifdef PROG_LOADER_OPCHECK_EN
    // ISA legality: nop, display memory, display register, load immediate
    logic op_ok_c;
    assign op_ok_c = (word_c == 16'h0000) ||
                     (word_c[15:11] == 5'd1) ||
                     (word_c[15:11] == 5'd2) ||
                     (word_c[15:13] == 3'b110);
`endif

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (start) next_state = S_LEN;
            S_LEN: begin
                if (acc_c) next_state = (len_n_c > DEPTH) ? S_ERR : S_HI;
            end
            S_HI: if (acc_c) next_state = S_LO;
            S_LO: begin
                if (acc_c) begin
                    next_state = (idx == last_idx) ? S_CSUM : S_HI;
`ifdef PROG_LOADER_OPCHECK_EN
                    if (!op_ok_c) next_state = S_ERR;
`endif
                end
            end
            S_CSUM: begin
                if (acc_c) next_state = (in_data == csum) ? S_DONE : S_ERR;
            end
            S_DONE: if (start) next_state = S_LEN;
            S_ERR:  if (start) next_state = S_LEN;
            default: next_state = S_IDLE;
        endcase
    end

    // datapath and registered outputs, all decoded from next_state / acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready     <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= 16'h0000;
            cpu_rst      <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
            csum         <= 8'h00;
            idx          <= '0;
            last_idx     <= '0;
            hi_byte      <= 8'h00;
        end else begin
            mem_we   <= 1'b0;
            in_ready <= (next_state == S_LEN) || (next_state == S_HI) ||
                        (next_state == S_LO)  || (next_state == S_CSUM);
            done     <= (next_state == S_DONE);
            err      <= (next_state == S_ERR);
            cpu_rst  <= (next_state != S_DONE);

            // a new load starts from a clean count and checksum
            if (next_state == S_LEN && state != S_LEN) begin
                words_loaded <= '0;
                csum         <= 8'h00;
            end

            case (state)
                S_LEN: begin
                    if (acc_c) begin
                        last_idx <= ADDR_W'(len_n_c - 9'd1);
                        idx      <= '0;
                    end
                end
                S_HI: begin
                    if (acc_c) begin
                        hi_byte <= in_data;
                        csum    <= csum ^ in_data;
                    end
                end
                S_LO: begin
                    if (acc_c) begin
                        csum <= csum ^ in_data;
                        // an aborted (illegal) word is never written
                        if (next_state != S_ERR) begin
                            mem_we       <= 1'b1;
                            mem_addr     <= idx;
                            mem_wdata    <= word_c;
                            words_loaded <= words_loaded + (ADDR_W+1)'(1);
                            if (idx != last_idx) idx <= idx + ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader (ADDR_W = 8).
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        err;
    logic [8:0]  words_loaded;

    int tests = 0;
    int fails = 0;

    logic [7:0]  log_addr [0:1023];
    logic [15:0] log_data [0:1023];
    int          wr_cnt = 0;

    prog_loader #(.ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_rst(cpu_rst), .done(done), .err(err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    // write logger, sampled on the falling edge
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            log_addr[wr_cnt] = mem_addr;
            log_data[wr_cnt] = mem_wdata;
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // present one byte from a falling edge; returns on the falling edge after acceptance
    task automatic send(input logic [7:0] b);
        int t;
        in_data  = b;
        in_valid = 1'b1;
        t = 0;
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (in_ready !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL send_timeout byte=%0h in_ready=%b expected=1", b, in_ready);
        end else begin
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    int          base;
    int          bad;
    logic [7:0]  cs;
    logic [7:0]  hb;
    logic [7:0]  lb;

    initial begin
        rst_n = 1'b0; start = 1'b0; in_data = 8'h00; in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_cpu_rst", 32'(cpu_rst), 1);
        chk("rst_done_err", 32'({done, err, mem_we}), 0);
        chk("rst_words", 32'(words_loaded), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 0);

        // two-word frame with good checksum
        pulse_start();
        chk("len_in_ready", 32'(in_ready), 1);
        base = wr_cnt;
        send(8'h02); send(8'hC1); send(8'h05); send(8'h08); send(8'h03); send(8'hCF);
        chk("t1_done", 32'(done), 1);
        chk("t1_err", 32'(err), 0);
        chk("t1_cpu_rst", 32'(cpu_rst), 0);
        chk("t1_in_ready", 32'(in_ready), 0);
        chk("t1_words", 32'(words_loaded), 2);
        chk("t1_nwr", 32'(wr_cnt - base), 2);
        chk("t1_w0", {8'(log_addr[base]), 8'h00, log_data[base]}, 32'h0000C105);
        chk("t1_w1", {8'(log_addr[base+1]), 8'h00, log_data[base+1]}, 32'h0100_0803);

        // start from DONE re-enters LEN
        pulse_start();
        chk("t5_done_clr", 32'(done), 0);
        chk("t5_cpu_rst", 32'(cpu_rst), 1);
        chk("t5_in_ready", 32'(in_ready), 1);
        chk("t5_words_clr", 32'(words_loaded), 0);

        // same frame, bad checksum, with an ignored start during HI
        base = wr_cnt;
        send(8'h02);
        pulse_start();
        chk("t5_hi_ready", 32'(in_ready), 1);
        send(8'hC1); send(8'h05); send(8'h08); send(8'h03); send(8'h00);
        chk("t2_err", 32'(err), 1);
        chk("t2_done", 32'(done), 0);
        chk("t2_cpu_rst", 32'(cpu_rst), 1);
        chk("t2_nwr", 32'(wr_cnt - base), 2);
        chk("t2_w1", {8'(log_addr[base+1]), 8'h00, log_data[base+1]}, 32'h0100_0803);

        // 256-word frame, valid on every other cycle
        pulse_start();
        base = wr_cnt;
        cs = 8'h00;
        send(8'h00); @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            hb = 8'(i);
            lb = 8'(i * 7 + 3);
            cs = cs ^ hb ^ lb;
            send(hb); @(negedge clk);
            send(lb); @(negedge clk);
        end
        send(cs);
        chk("t3_done", 32'(done), 1);
        chk("t3_words", 32'(words_loaded), 256);
        chk("t3_nwr", 32'(wr_cnt - base), 256);
        chk("t3_last_addr", 32'(log_addr[base+255]), 32'hFF);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (log_addr[base+i] !== 8'(i) || log_data[base+i] !== {8'(i), 8'(i * 7 + 3)}) bad++;
        end
        chk("t3_data_bad", 32'(bad), 0);

        // asynchronous reset mid-load
        pulse_start();
        send(8'h02); send(8'hC1); send(8'h05); send(8'h08);
        rst_n = 1'b0;
        #1;
        chk("t4_in_ready", 32'(in_ready), 0);
        chk("t4_cpu_rst", 32'(cpu_rst), 1);
        chk("t4_flags", 32'({done, err, mem_we}), 0);
        chk("t4_addr", 32'(mem_addr), 0);
        chk("t4_wdata", 32'(mem_wdata), 0);
        chk("t4_words", 32'(words_loaded), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        base = wr_cnt;
        send(8'h02); send(8'hC1); send(8'h05); send(8'h08); send(8'h03); send(8'hCF);
        chk("t4_done", 32'(done), 1);
        chk("t4_reload_words", 32'(words_loaded), 2);
        chk("t4_reload_w0", 32'(log_data[base]), 32'hC105);

        // opcode check frame: 3800 is not a legal instruction
        pulse_start();
        base = wr_cnt;
        send(8'h01); send(8'h38); send(8'h00);
`ifdef PROG_LOADER_OPCHECK_EN
        @(negedge clk);
        chk("t6_err", 32'(err), 1);
        chk("t6_done", 32'(done), 0);
        chk("t6_nwr", 32'(wr_cnt - base), 0);
        chk("t6_in_ready", 32'(in_ready), 0);
`else
        send(8'h38);
        chk("t6_done", 32'(done), 1);
        chk("t6_err", 32'(err), 0);
        chk("t6_nwr", 32'(wr_cnt - base), 1);
        chk("t6_w0", {8'(log_addr[base]), 8'h00, log_data[base]}, 32'h0000_3800);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
